// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle CPU control path and datapath decoders.
// Opcodes, FSM state codes, mux-select codes and the packed control-strobe bundle.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/datapath boundary of the multi-cycle CPU: opcode and handshake in,
// resource strobes and the current state out.
interface mc_control_fsm_if;
  import mc_pkg::*;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  state_t     state;

  // zero is consumed by the datapath's PCWriteCond AND gate, never by the controller
  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-strobe decoder for the multi-cycle control FSM.
// Everything is forced low while reset is asserted so no write can escape.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic       rst,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b  = SRCB_IMM_SH2;
          ctrl.illegal_op = !is_legal_op(opcode);
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        S_ADDIEX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          ctrl.reg_write = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle CPU: state register and next-state logic;
// strobes come from mc_ctrl_decode as a pure decode of the current state.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 written when memory is ready
// DECODE | compute branch target, dispatch on opcode, flag illegal opcodes
// MEMADR | compute load/store effective address
// MEMRD  | load data read, waits for mem_ready
// MEMWB  | load data written to rt
// MEMWR  | store write, waits for mem_ready
// EXEC   | R-type ALU operation
// RWB    | R-type result written to rd
// BRANCH | beq compare, PC updated if zero
// JUMP   | PC loaded with jump target
// ADDIEX | addi ALU operation
// ADDIWB | addi result written to rt
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mc_control_fsm_if.master bus
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_FETCH;
        endcase
      end
      // only lw/sw reach MEMADR and the IR is stable, so sw vs. not-sw suffices
      S_MEMADR: state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_RWB;
      S_RWB:    state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .rst       (rst),
    .mem_ready (bus.mem_ready),
    .opcode    (bus.opcode),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.state       = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instructions expand into per-cycle phase lists
// (with stalls) and every cycle's strobes and state are compared to a phase table.
module tb_mc_control_fsm;
  import mc_pkg::*;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_EXEC, P_RWB, P_BRANCH, P_JUMP, P_ADDIEX, P_ADDIWB
  } phase_t;

  typedef struct {
    phase_t ph;
    logic   rdy;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] obs_vec();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
  endfunction

  // Expected strobes straight from the per-state output table
  function automatic logic [16:0] exp_vec(input phase_t ph, input logic rdy, input logic [5:0] op);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, sa = 0, ill = 0;
    logic [1:0] sb = 0, aop = 0, pcs = 0;
    case (ph)
      P_FETCH:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      P_DECODE: begin sb = 2'b11; ill = !legal(op); end
      P_MEMADR: begin sa = 1; sb = 2'b10; end
      P_MEMRD:  begin mrd = 1; iord = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin mwr = 1; iord = 1; end
      P_EXEC:   begin sa = 1; aop = 2'b10; end
      P_RWB:    begin rw = 1; rdst = 1; end
      P_BRANCH: begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      P_JUMP:   begin pcw = 1; pcs = 2'b10; end
      P_ADDIEX: begin sa = 1; sb = 2'b10; end
      P_ADDIWB: begin rw = 1; end
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs, ill};
  endfunction

  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input int abort_at, input logic zbit);
    cyc_t q[$];
    for (int k = 0; k < fstall; k++) q.push_back('{P_FETCH, 1'b0});
    q.push_back('{P_FETCH, 1'b1});
    q.push_back('{P_DECODE, 1'($urandom_range(0, 1))});
    case (op)
      6'h23: begin
        q.push_back('{P_MEMADR, 1'($urandom_range(0, 1))});
        for (int k = 0; k < mstall; k++) q.push_back('{P_MEMRD, 1'b0});
        q.push_back('{P_MEMRD, 1'b1});
        q.push_back('{P_MEMWB, 1'($urandom_range(0, 1))});
      end
      6'h2B: begin
        q.push_back('{P_MEMADR, 1'($urandom_range(0, 1))});
        for (int k = 0; k < mstall; k++) q.push_back('{P_MEMWR, 1'b0});
        q.push_back('{P_MEMWR, 1'b1});
      end
      6'h00: begin
        q.push_back('{P_EXEC, 1'($urandom_range(0, 1))});
        q.push_back('{P_RWB, 1'($urandom_range(0, 1))});
      end
      6'h04: q.push_back('{P_BRANCH, 1'($urandom_range(0, 1))});
      6'h02: q.push_back('{P_JUMP, 1'($urandom_range(0, 1))});
      6'h08: begin
        q.push_back('{P_ADDIEX, 1'($urandom_range(0, 1))});
        q.push_back('{P_ADDIWB, 1'($urandom_range(0, 1))});
      end
      default: ;
    endcase

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst           = 1'b1;
      bus.opcode    = op;
      bus.zero      = zbit;
      bus.mem_ready = q[i].rdy;
      #1;
      check($sformatf("op%02h cyc%0d strobes", op, i), 32'(obs_vec()), 32'(exp_vec(q[i].ph, q[i].rdy, op)));
      check($sformatf("op%02h cyc%0d state", op, i), 32'(bus.state), 32'(q[i].ph));
      if (i == abort_at) begin
        #1 rst = 1'b0;
        #1;
        check($sformatf("op%02h abort strobes", op), 32'(obs_vec()), 32'd0);
        check($sformatf("op%02h abort state", op), 32'(bus.state), 32'(P_FETCH));
        @(posedge clk);
        #1;
        check($sformatf("op%02h abort hold strobes", op), 32'(obs_vec()), 32'd0);
        check($sformatf("op%02h abort hold state", op), 32'(bus.state), 32'(P_FETCH));
        return;
      end
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] ops [6] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    bus.opcode    = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset strobes", 32'(obs_vec()), 32'd0);
      check("reset state", 32'(bus.state), 32'(P_FETCH));
    end

    run_instr(6'h23, 0, 0, -1, 1'b0);
    run_instr(6'h2B, 0, 2, -1, 1'b0);
    run_instr(6'h04, 0, 0, -1, 1'b0);
    run_instr(6'h04, 0, 0, -1, 1'b1);
    run_instr(6'h02, 0, 0, -1, 1'b0);
    run_instr(6'h00, 0, 0, -1, 1'b0);
    run_instr(6'h08, 0, 0, -1, 1'b0);
    run_instr(6'h3F, 0, 0, -1, 1'b0);
    run_instr(6'h00, 0, 0, 2, 1'b0);   // reset lands in EXEC
    run_instr(6'h2B, 1, 3, 4, 1'b0);   // reset lands in a stalled store
    run_instr(6'h23, 1, 1, -1, 1'b1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom);
        if (legal(op)) op = 6'h3F;
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1,
                1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
